// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU execute stage.
package alu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SLL    = 4'd5,
        OP_SRL    = 4'd6,
        OP_CMP    = 4'd7,
        OP_PASS_B = 4'd8,
        OP_MUL    = 4'd9
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } exec_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier iterator: one multiplier bit per step, W steps per product.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product_next,
    output logic           last
);

    localparam int CNT_W = $clog2(W);

    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    // NOTE: every register here is reset, so an aborted product never leaks into the next one.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
            acc    <= product_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    // Accumulator value after the current step; the final step's value is the full product.
    assign product_next = acc + (mplier[0] ? mcand : '0);
    assign last         = (cnt == CNT_W'(W - 1));

endmodule

// File: rtl/alu_exec_unit.sv
// Registered ALU execute stage: single-cycle ops plus a W-cycle shift-add MUL.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         Start,
    input  logic [3:0]   ALU_Op,
    input  logic [W-1:0] SrcA_in,
    input  logic [W-1:0] SrcB_in,
    output logic [W-1:0] Result,
    output logic         Carry,
    output logic         Zero,
    output logic         Neg,
    output logic         Busy,
    output logic         Done
);

    exec_state_t state, state_next;

    logic           accept, mul_launch, single_op, mul_step, mul_last, mul_finish;
    logic [2*W-1:0] mul_product;

    logic [W:0]     sum, diff, sll_w, srl_w;
    logic [W-1:0]   alu_res;
    logic           alu_c, upd_res, upd_flags;

    assign accept     = (state == IDLE) && Start;
    assign mul_launch = accept && (ALU_Op == OP_MUL);
    assign single_op  = accept && (ALU_Op != OP_MUL);
    assign mul_finish = mul_step && mul_last;

    alu_mul_seq #(.W(W)) u_mul (
        .CLK          (CLK),
        .reset        (reset),
        .load         (mul_launch),
        .step         (mul_step),
        .a            (SrcA_in),
        .b            (SrcB_in),
        .product_next (mul_product),
        .last         (mul_last)
    );

    // Extra top bit carries out of ADD/SLL and the borrow of SUB/CMP; SRL's bit 0 is the shifted-out bit.
    assign sum   = {1'b0, SrcA_in} + {1'b0, SrcB_in};
    assign diff  = {1'b0, SrcA_in} - {1'b0, SrcB_in};
    assign sll_w = {1'b0, SrcA_in} << SrcB_in[2:0];
    assign srl_w = {SrcA_in, 1'b0} >> SrcB_in[2:0];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        upd_res   = 1'b1;
        upd_flags = 1'b1;
        case (ALU_Op)
            OP_ADD:    {alu_c, alu_res} = sum;
            OP_SUB:    {alu_c, alu_res} = diff;
            OP_AND:    alu_res = SrcA_in & SrcB_in;
            OP_OR:     alu_res = SrcA_in | SrcB_in;
            OP_XOR:    alu_res = SrcA_in ^ SrcB_in;
            OP_SLL:    {alu_c, alu_res} = sll_w;
            OP_SRL:    {alu_res, alu_c} = srl_w;
            OP_PASS_B: alu_res = SrcB_in;
            OP_CMP: begin
                // Flags come from A-B but the visible Result is left alone.
                {alu_c, alu_res} = diff;
                upd_res          = 1'b0;
            end
            default: begin
                upd_res   = 1'b0;
                upd_flags = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mul_launch) state_next = MUL;
            MUL:     if (mul_last)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy     = (state == MUL);
        mul_step = (state == MUL);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            Result <= '0;
            Carry  <= 1'b0;
            Zero   <= 1'b0;
            Neg    <= 1'b0;
            Done   <= 1'b0;
        end else begin
            Done <= single_op || mul_finish;
            if (single_op) begin
                if (upd_res) Result <= alu_res;
                if (upd_flags) begin
                    Carry <= alu_c;
                    Zero  <= (alu_res == '0);
                    Neg   <= alu_res[W-1];
                end
            end else if (mul_finish) begin
                Result <= mul_product[W-1:0];
                Carry  <= |mul_product[2*W-1:W];
                Zero   <= (mul_product[W-1:0] == '0);
                Neg    <= mul_product[W-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed, table-driven bench for alu_exec_unit with hand-written MUL/reset sequences.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = DATA_W;

    logic         CLK = 1'b0;
    logic         reset, Start;
    logic [3:0]   ALU_Op;
    logic [W-1:0] SrcA_in, SrcB_in, Result;
    logic         Carry, Zero, Neg, Busy, Done;

    int pass_count  = 0;
    int check_count = 0;

    always #5 CLK = ~CLK;

    alu_exec_unit #(.W(W)) dut (
        .CLK     (CLK),
        .reset   (reset),
        .Start   (Start),
        .ALU_Op  (ALU_Op),
        .SrcA_in (SrcA_in),
        .SrcB_in (SrcB_in),
        .Result  (Result),
        .Carry   (Carry),
        .Zero    (Zero),
        .Neg     (Neg),
        .Busy    (Busy),
        .Done    (Done)
    );

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [2:0] czn;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] res, input logic [2:0] czn, input logic poke);
        @(negedge CLK);
        Start = 1'b1; ALU_Op = OP_MUL; SrcA_in = a; SrcB_in = b;
        @(negedge CLK);
        // Scramble operands and optionally hammer Start with an ADD that must be ignored.
        SrcA_in = 8'hEE; SrcB_in = 8'hEE; ALU_Op = OP_ADD; Start = poke;
        check({tag, "_busy0"}, {14'd0, Busy, Done}, 16'b10);
        for (int i = 1; i < W; i++) begin
            @(negedge CLK);
            check($sformatf("%s_busy%0d", tag, i), {14'd0, Busy, Done}, 16'b10);
        end
        @(negedge CLK);
        Start = 1'b0;
        check({tag, "_done"}, {14'd0, Busy, Done}, 16'b01);
        check({tag, "_res"},  {8'd0, Result}, {8'd0, res});
        check({tag, "_czn"},  {13'd0, Carry, Zero, Neg}, {13'd0, czn});
        @(negedge CLK);
        check({tag, "_after"}, {7'd0, Done, Result}, {7'd0, 1'b0, res});
    endtask

    initial begin
        logic saw_done;

        vecs[0]  = '{OP_ADD,    8'h05, 8'hFF, 8'h04, 3'b100};
        vecs[1]  = '{4'hF,      8'h00, 8'h00, 8'h04, 3'b100};
        vecs[2]  = '{OP_SUB,    8'h03, 8'h05, 8'hFE, 3'b101};
        vecs[3]  = '{OP_CMP,    8'h42, 8'h42, 8'hFE, 3'b010};
        vecs[4]  = '{OP_SLL,    8'h81, 8'h01, 8'h02, 3'b100};
        vecs[5]  = '{OP_SRL,    8'h81, 8'h00, 8'h81, 3'b001};
        vecs[6]  = '{OP_AND,    8'hF0, 8'h0F, 8'h00, 3'b010};
        vecs[7]  = '{OP_OR,     8'hF0, 8'h0F, 8'hFF, 3'b001};
        vecs[8]  = '{OP_XOR,    8'hAA, 8'hFF, 8'h55, 3'b000};
        vecs[9]  = '{OP_PASS_B, 8'h12, 8'h80, 8'h80, 3'b001};
        vecs[10] = '{OP_SLL,    8'h81, 8'h07, 8'h80, 3'b001};
        vecs[11] = '{OP_SRL,    8'h85, 8'h03, 8'h10, 3'b100};
        vecs[12] = '{OP_ADD,    8'h80, 8'h80, 8'h00, 3'b110};
        vecs[13] = '{OP_CMP,    8'h01, 8'h02, 8'h00, 3'b101};
        vecs[14] = '{OP_SUB,    8'h07, 8'h07, 8'h00, 3'b010};

        reset = 1'b1; Start = 1'b0; ALU_Op = 4'd0; SrcA_in = '0; SrcB_in = '0;
        @(negedge CLK);
        check("reset_state", {3'd0, Result, Carry, Zero, Neg, Busy, Done}, 16'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge CLK);
            Start = 1'b1; ALU_Op = vecs[i].op; SrcA_in = vecs[i].a; SrcB_in = vecs[i].b;
            @(negedge CLK);
            Start = 1'b0;
            check($sformatf("vec%0d_res", i),  {8'd0, Result}, {8'd0, vecs[i].res});
            check($sformatf("vec%0d_czn", i),  {13'd0, Carry, Zero, Neg}, {13'd0, vecs[i].czn});
            check($sformatf("vec%0d_done", i), {14'd0, Busy, Done}, 16'b01);
            @(negedge CLK);
            check($sformatf("vec%0d_done_low", i), {15'd0, Done}, 16'd0);
        end

        // Back-to-back: Start held high through the Done cycle is accepted again.
        @(negedge CLK);
        Start = 1'b1; ALU_Op = OP_ADD; SrcA_in = 8'h01; SrcB_in = 8'h01;
        @(negedge CLK);
        check("b2b_first", {7'd0, Done, Result}, {7'd0, 1'b1, 8'h02});
        ALU_Op = OP_SUB; SrcA_in = 8'h05; SrcB_in = 8'h03;
        @(negedge CLK);
        Start = 1'b0;
        check("b2b_second", {4'd0, Done, Carry, Zero, Neg, Result}, {4'd0, 4'b1000, 8'h02});
        @(negedge CLK);
        check("b2b_done_low", {15'd0, Done}, 16'd0);

        run_mul("mul_ffxff", 8'hFF, 8'hFF, 8'h01, 3'b100, 1'b1);
        run_mul("mul_10x11", 8'h10, 8'h11, 8'h10, 3'b100, 1'b1);
        run_mul("mul_00x55", 8'h00, 8'h55, 8'h00, 3'b010, 1'b0);
        run_mul("mul_0fx0f", 8'h0F, 8'h0F, 8'hE1, 3'b001, 1'b0);

        // Reset during the fourth MUL cycle: outputs clear at once, nothing completes later.
        @(negedge CLK);
        Start = 1'b1; ALU_Op = OP_MUL; SrcA_in = 8'h10; SrcB_in = 8'h11;
        @(negedge CLK);
        Start = 1'b0;
        repeat (3) @(negedge CLK);
        check("pre_reset_busy", {15'd0, Busy}, 16'd1);
        reset = 1'b1;
        #1;
        check("mid_mul_reset", {3'd0, Result, Carry, Zero, Neg, Busy, Done}, 16'd0);
        @(negedge CLK);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            saw_done = saw_done | Done | Busy;
        end
        check("no_stray_mul", {15'd0, saw_done}, 16'd0);
        Start = 1'b1; ALU_Op = OP_ADD; SrcA_in = 8'h01; SrcB_in = 8'h01;
        @(negedge CLK);
        Start = 1'b0;
        check("post_reset_add", {4'd0, Done, Carry, Zero, Neg, Result}, {4'd0, 4'b1000, 8'h02});

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
